// File: rtl/ex_mem_if.sv
// EX->MEM stage bus: upstream EX handshake, downstream MEM handshake, branch and flags outputs.
// slave = the pipeline stage itself, master = the surrounding pipeline driving it.
interface ex_mem_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ADDR_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_alu;
  logic                  in_cout;
  logic                  in_zero;
  logic                  in_equal;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_wb_en;
  logic                  in_flags_upd;
  logic [1:0]            in_br_type;
  logic [ADDR_WIDTH-1:0] in_br_target;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_alu;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wb_en;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [2:0]            flags;

  modport slave (
    input  in_valid, in_alu, in_cout, in_zero, in_equal, in_rd, in_wb_en,
           in_flags_upd, in_br_type, in_br_target, flush, out_ready,
    output in_ready, out_valid, out_alu, out_rd, out_wb_en, br_taken,
           br_target, flags
  );

  modport master (
    output in_valid, in_alu, in_cout, in_zero, in_equal, in_rd, in_wb_en,
           in_flags_upd, in_br_type, in_br_target, flush, out_ready,
    input  in_ready, out_valid, out_alu, out_rd, out_wb_en, br_taken,
           br_target, flags
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolution and architectural flags.
// Define EX_MEM_SKID_EN for a two-entry skid buffer with a registered in_ready.
module ex_mem_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ADDR_WIDTH = 16
) (
  input logic   clk,
  input logic   rst_n,
  ex_mem_if.slave bus
);
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_Z    = 2'b11;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_alu_q, out_alu_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_wb_en_q, out_wb_en_d;
  logic                  br_taken_q, br_taken_d;
  logic [ADDR_WIDTH-1:0] br_target_q, br_target_d;
  logic [2:0]            flags_q, flags_d;
  logic                  in_ready_w;
  logic                  accept;
  logic                  br_cond;
`ifdef EX_MEM_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_alu_q, skid_alu_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic                  skid_wb_en_q, skid_wb_en_d;
  logic                  in_ready_q, in_ready_d;

  assign in_ready_w = in_ready_q;
`else
  assign in_ready_w = bus.out_ready | ~out_valid_q;
`endif

  // A flushed cycle never counts as an accept, so it cannot pulse or touch flags.
  assign accept = bus.in_valid & in_ready_w & ~bus.flush;

  always_comb begin
    case (bus.in_br_type)
      BR_EQ:   br_cond = bus.in_equal;
      BR_NE:   br_cond = ~bus.in_equal;
      BR_Z:    br_cond = bus.in_zero;
      BR_NONE: br_cond = 1'b0;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_alu_d   = out_alu_q;
    out_rd_d    = out_rd_q;
    out_wb_en_d = out_wb_en_q;
    br_taken_d  = accept & br_cond;
    br_target_d = (accept & br_cond) ? bus.in_br_target : '0;
    flags_d     = (accept & bus.in_flags_upd) ?
                  {bus.in_cout, bus.in_zero, bus.in_equal} : flags_q;
`ifdef EX_MEM_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_alu_d   = skid_alu_q;
    skid_rd_d    = skid_rd_q;
    skid_wb_en_d = skid_wb_en_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        // Older skid entry moves forward first to keep FIFO order.
        out_valid_d  = 1'b1;
        out_alu_d    = skid_alu_q;
        out_rd_d     = skid_rd_q;
        out_wb_en_d  = skid_wb_en_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_alu_d   = bus.in_alu;
          skid_rd_d    = bus.in_rd;
          skid_wb_en_d = bus.in_wb_en;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_alu_d   = bus.in_alu;
          out_rd_d    = bus.in_rd;
          out_wb_en_d = bus.in_wb_en;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_alu_d   = bus.in_alu;
      skid_rd_d    = bus.in_rd;
      skid_wb_en_d = bus.in_wb_en;
    end
    in_ready_d = ~skid_valid_d;
`else
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_alu_d   = bus.in_alu;
      out_rd_d    = bus.in_rd;
      out_wb_en_d = bus.in_wb_en;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_alu_q    <= '0;
      out_rd_q     <= '0;
      out_wb_en_q  <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
      flags_q      <= '0;
`ifdef EX_MEM_SKID_EN
      skid_valid_q <= 1'b0;
      skid_alu_q   <= '0;
      skid_rd_q    <= '0;
      skid_wb_en_q <= 1'b0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_alu_q    <= out_alu_d;
      out_rd_q     <= out_rd_d;
      out_wb_en_q  <= out_wb_en_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
      flags_q      <= flags_d;
`ifdef EX_MEM_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_alu_q   <= skid_alu_d;
      skid_rd_q    <= skid_rd_d;
      skid_wb_en_q <= skid_wb_en_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_alu   = out_alu_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wb_en = out_wb_en_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; expectations follow whichever EX_MEM_SKID_EN build is compiled.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  ex_mem_if #(.DATA_WIDTH(16), .REG_ADDR_W(3), .ADDR_WIDTH(16)) bus ();

  ex_mem_stage #(.DATA_WIDTH(16), .REG_ADDR_W(3), .ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [2:0] rd,
                       input logic wb, input logic [1:0] bt, input logic [15:0] tgt,
                       input logic co, input logic z, input logic eq, input logic fu);
    bus.in_valid     = v;
    bus.in_alu       = alu;
    bus.in_rd        = rd;
    bus.in_wb_en     = wb;
    bus.in_br_type   = bt;
    bus.in_br_target = tgt;
    bus.in_cout      = co;
    bus.in_zero      = z;
    bus.in_equal     = eq;
    bus.in_flags_upd = fu;
  endtask

  initial begin
    logic [15:0] vals [3];
    int          idx;
    int          got_n;
    vals[0] = 16'h0001;
    vals[1] = 16'h0002;
    vals[2] = 16'h0003;

    drive(1'b0, 16'h0, 3'd0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst flags", {29'b0, bus.flags}, 32'd0);
    check("rst br_taken", {31'b0, bus.br_taken}, 32'd0);
    check("rst out_alu", {16'b0, bus.out_alu}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // basic pass-through
    drive(1'b1, 16'h1234, 3'd3, 1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t1 out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("t1 out_alu", {16'b0, bus.out_alu}, 32'h1234);
    check("t1 out_rd", {29'b0, bus.out_rd}, 32'd3);
    check("t1 out_wb_en", {31'b0, bus.out_wb_en}, 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("t1 drained", {31'b0, bus.out_valid}, 32'd0);

    // branches
    drive(1'b1, 16'h0, 3'd0, 1'b0, 2'b01, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("t2 beq taken", {31'b0, bus.br_taken}, 32'd1);
    check("t2 beq target", {16'b0, bus.br_target}, 32'h0040);
    bus.in_valid = 1'b0;
    step();
    check("t2 pulse ends", {31'b0, bus.br_taken}, 32'd0);
    drive(1'b1, 16'h0, 3'd0, 1'b0, 2'b10, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("t2 bne not taken", {31'b0, bus.br_taken}, 32'd0);
    drive(1'b1, 16'h0, 3'd0, 1'b0, 2'b11, 16'h00c0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("t2 bz taken", {31'b0, bus.br_taken}, 32'd1);
    check("t2 bz target", {16'b0, bus.br_target}, 32'h00c0);
    bus.in_valid = 1'b0;
    step();

    // backpressure and ordering
    bus.out_ready = 1'b0;
    drive(1'b1, vals[0], 3'd1, 1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t3 ready A", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_alu = vals[1];
    #1;
    check("t3 ready B", {31'b0, bus.in_ready}, {31'b0, SKID});
    step();
    idx = SKID ? 2 : 1;
    bus.in_alu = vals[idx];
    #1;
    check("t3 ready full", {31'b0, bus.in_ready}, 32'd0);
    step();
    check("t3 hold valid", {31'b0, bus.out_valid}, 32'd1);
    check("t3 hold A", {16'b0, bus.out_alu}, {16'b0, vals[0]});
    bus.out_ready = 1'b1;
    got_n = 0;
    for (int cyc = 0; cyc < 20 && got_n < 3; cyc++) begin
      bus.in_valid = (idx < 3);
      bus.in_alu   = (idx < 3) ? vals[idx] : 16'h0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("t3 order %0d", got_n), {16'b0, bus.out_alu}, {16'b0, vals[got_n]});
        got_n++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("t3 count", got_n, 32'd3);
    bus.in_valid = 1'b0;
    step();

    // flags
    drive(1'b1, 16'h0, 3'd0, 1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("t4 flags set", {29'b0, bus.flags}, 32'b101);
    drive(1'b1, 16'h0, 3'd0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("t4 flags hold", {29'b0, bus.flags}, 32'b101);
    bus.in_valid = 1'b0;
    step();

    // flush with entries held and a same-cycle branch input
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00d0, 3'd4, 1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_alu = 16'h00e0;
    step();
    check("t5 held", {31'b0, bus.out_valid}, 32'd1);
    drive(1'b1, 16'h00f0, 3'd5, 1'b0, 2'b11, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.flush = 1'b1;
    step();
    check("t5 out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t5 no br", {31'b0, bus.br_taken}, 32'd0);
    check("t5 flags", {29'b0, bus.flags}, 32'b101);
    check("t5 in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("t5 no stale", {31'b0, bus.out_valid}, 32'd0);

    // asynchronous reset between edges
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0abc, 3'd6, 1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("t6 pre valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t6 flags", {29'b0, bus.flags}, 32'd0);
    check("t6 in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t6 out_alu", {16'b0, bus.out_alu}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
